// File: rtl/imm_decode_stage.sv
// ============================================================================
// imm_decode_stage
// ----------------------------------------------------------------------------
// Purpose:
//   Decodes the immediate field of a 32-bit RISC-V instruction word and
//   extends it to XLEN bits. Each decoded result goes into a small FIFO that
//   has valid/ready handshakes on both sides. A result pushed into an empty
//   buffer is presented on the next cycle.
//
// Parameters:
//   XLEN  - width of the extended immediate (32 or 64)
//   DEPTH - number of result buffer entries (power of two, >= 2)
//
// Ports:
//   clk         in   1              rising-edge clock
//   rst_n       in   1              synchronous active-low reset
//   in_valid    in   1              an instruction is offered
//   in_ready    out  1              buffer has room (occupancy != DEPTH)
//   inst        in   32             instruction word
//   imm_src     in   3              immediate format select
//   out_valid   out  1              a result is presented (occupancy != 0)
//   out_ready   in   1              consumer takes the head result
//   imm_ext     out  XLEN           head result, 0 when empty
//   imm_illegal out  1              head result came from imm_src 3'b111
//   occupancy   out  $clog2(DEPTH)+1 number of valid entries
//   perf_count  out  16             pop counter, saturating at 0xFFFF
//                                   (only with IMM_DECODE_PERF_EN defined)
//
// Configuration macro:
//   IMM_DECODE_PERF_EN - adds the perf_count port and its counter.
// ============================================================================
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                inst,
    input  logic [2:0]                 imm_src,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            imm_ext,
    output logic                       imm_illegal,
    output logic [$clog2(DEPTH):0]     occupancy
`ifdef IMM_DECODE_PERF_EN
    ,
    output logic [15:0]                perf_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [31:0]      imm32;
    logic [XLEN-1:0]  dec_imm;
    logic             dec_illegal;

    logic [XLEN-1:0]  imm_mem_q [DEPTH];
    logic [XLEN-1:0]  imm_mem_d [DEPTH];
    logic             ill_mem_q [DEPTH];
    logic             ill_mem_d [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    logic             push;
    logic             pop;

    // The opcode bits never affect the immediate. They are folded into a
    // signal that is explicitly named as unused.
    logic             unused_opcode;
    assign unused_opcode = ^inst[6:0];

    // Every format is first built as a 32-bit value whose bit 31 is the
    // correct sign. A single signed cast then extends it to XLEN. The
    // zero-extended formats (I-shift, Z) always have bit 31 clear, so the
    // same cast zero-extends them.
    always_comb begin
        imm32       = '0;
        dec_illegal = 1'b0;
        case (imm_src)
            3'b000: imm32 = {{20{inst[31]}}, inst[31:20]};
            3'b001: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            3'b010: imm32 = {inst[31:12], 12'b0};
            3'b011: begin
                if (XLEN == 64) imm32 = {26'b0, inst[25:20]};
                else            imm32 = {27'b0, inst[24:20]};
            end
            3'b100: imm32 = {27'b0, inst[19:15]};
            3'b101: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                             inst[11:8], 1'b0};
            3'b110: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                             inst[30:21], 1'b0};
            default: dec_illegal = 1'b1;
        endcase
        dec_imm = XLEN'($signed(imm32));
    end

    // The handshake status depends only on registered occupancy, so in_ready
    // has no combinational path from out_ready. When the buffer is full,
    // in_ready is 0, and a push is refused even if a pop happens in the
    // same cycle.
    always_comb begin
        in_ready  = (occ_q != OCC_W'(DEPTH));
        out_valid = (occ_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        occupancy = occ_q;
    end

    // Next-state logic for the buffer. The pointers are PTR_W bits wide and
    // DEPTH is a power of two, so they wrap modulo DEPTH by themselves.
    // A push and a pop together leave the occupancy unchanged.
    always_comb begin
        imm_mem_d = imm_mem_q;
        ill_mem_d = ill_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        if (push) begin
            imm_mem_d[wr_ptr_q] = dec_imm;
            ill_mem_d[wr_ptr_q] = dec_illegal;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Control state. Reset clears the pointers and the occupancy and
    // overrides any push or pop in the same cycle. This discards everything
    // that was buffered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is not reset. An entry can only be read after a push writes
    // it, and the outputs are forced to zero while the buffer is empty.
    // Writes are blocked during reset so the reset cycle leaves no trace.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            imm_mem_q <= imm_mem_d;
            ill_mem_q <= ill_mem_d;
        end
    end

    // The head entry drives the outputs. It stays stable under backpressure
    // because rd_ptr only moves on a pop.
    always_comb begin
        imm_ext     = '0;
        imm_illegal = 1'b0;
        if (out_valid) begin
            imm_ext     = imm_mem_q[rd_ptr_q];
            imm_illegal = ill_mem_q[rd_ptr_q];
        end
    end

`ifdef IMM_DECODE_PERF_EN
    logic [15:0] perf_q, perf_d;

    // Counts pops and holds at 0xFFFF instead of wrapping.
    always_comb begin
        perf_d = perf_q;
        if (pop && (perf_q != 16'hFFFF)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    // Pop counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_count = perf_q;
`endif

endmodule
